// File: rtl/vga_box_renderer.sv
// vga_box_renderer: pixel-colour stage for a bouncing bordered rectangle.
// Registers an RGB565 colour per pixel with one cycle of latency and moves
// the rectangle by STEP pixels per axis on frame-tick driven updates,
// reflecting off the screen edges and counting wall hits.
module vga_box_renderer #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BOX_W        = 32,
    parameter int          BOX_H        = 32,
    parameter int          STEP         = 2,
    parameter int          FRAME_DIV    = 1,
    parameter logic [15:0] BOX_COLOR    = 16'hF800,
    parameter logic [15:0] BORDER_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR     = 16'h001F
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_active,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [4:0] vga_r,
    output logic [5:0] vga_g,
    output logic [4:0] vga_b,
    output logic       pix_active_q,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [7:0] bounce_count
);

    localparam int          DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [9:0]  X_MAX    = 10'(H_ACTIVE - BOX_W);
    localparam logic [9:0]  Y_MAX    = 10'(V_ACTIVE - BOX_H);
    localparam logic [9:0]  X_HOME   = 10'((H_ACTIVE - BOX_W) / 2);
    localparam logic [9:0]  Y_HOME   = 10'((V_ACTIVE - BOX_H) / 2);
    localparam logic [9:0]  STEP_V   = 10'(STEP);
    localparam logic [10:0] BOX_W_M1 = 11'(BOX_W - 1);
    localparam logic [10:0] BOX_H_M1 = 11'(BOX_H - 1);
    localparam logic        DIR_POS  = 1'b0;
    localparam logic        DIR_NEG  = 1'b1;

    // One axis of motion: returns {hit, next_dir, next_pos}. A forward step
    // that would reach or pass the far limit clamps to it; a backward step
    // that would reach or pass zero clamps to zero. Both reverse direction.
    function automatic logic [11:0] axis_step(input logic [9:0] pos,
                                              input logic       dir,
                                              input logic [9:0] lim);
        logic [10:0] fwd;
        logic [11:0] res;
        fwd = {1'b0, pos} + {1'b0, STEP_V};
        if (dir == DIR_POS) begin
            if (fwd >= {1'b0, lim}) begin
                res = {1'b1, DIR_NEG, lim};
            end else begin
                res = {1'b0, DIR_POS, fwd[9:0]};
            end
        end else begin
            if (pos <= STEP_V) begin
                res = {1'b1, DIR_POS, 10'd0};
            end else begin
                res = {1'b0, DIR_NEG, pos - STEP_V};
            end
        end
        return res;
    endfunction

    logic [9:0]       box_x_r, box_y_r;
    logic             dir_x_r, dir_y_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [7:0]       bounce_r;
    logic [15:0]      colour_r;
    logic             pix_active_q_r;

    logic [DIV_W-1:0] div_cnt_nxt_s;
    logic             update_s;
    logic [11:0]      step_x_s, step_y_s;
    logic [9:0]       box_x_nxt_s, box_y_nxt_s;
    logic             dir_x_nxt_s, dir_y_nxt_s;
    logic [8:0]       bounce_sum_s;
    logic [7:0]       bounce_nxt_s;
    logic [10:0]      px_s, py_s, bx_s, by_s;
    logic             inside_s, edge_s;
    logic [15:0]      colour_nxt_s;

    // Frame divider: counts enabled frame ticks and fires one update per FRAME_DIV.
    always_comb begin
        div_cnt_nxt_s = div_cnt_r;
        update_s      = 1'b0;
        if (frame_tick && enable) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_nxt_s = '0;
                update_s      = 1'b1;
            end else begin
                div_cnt_nxt_s = div_cnt_r + 1'b1;
                update_s      = 1'b0;
            end
        end else begin
            div_cnt_nxt_s = div_cnt_r;
            update_s      = 1'b0;
        end
    end

    // Motion next-state: per-axis step/bounce and saturating wall-hit count.
    always_comb begin
        step_x_s     = axis_step(box_x_r, dir_x_r, X_MAX);
        step_y_s     = axis_step(box_y_r, dir_y_r, Y_MAX);
        box_x_nxt_s  = box_x_r;
        box_y_nxt_s  = box_y_r;
        dir_x_nxt_s  = dir_x_r;
        dir_y_nxt_s  = dir_y_r;
        bounce_sum_s = {1'b0, bounce_r};
        bounce_nxt_s = bounce_r;
        if (update_s) begin
            box_x_nxt_s  = step_x_s[9:0];
            dir_x_nxt_s  = step_x_s[10];
            box_y_nxt_s  = step_y_s[9:0];
            dir_y_nxt_s  = step_y_s[10];
            bounce_sum_s = {1'b0, bounce_r} + {8'd0, step_x_s[11]} + {8'd0, step_y_s[11]};
            if (bounce_sum_s > 9'd255) begin
                bounce_nxt_s = 8'd255;
            end else begin
                bounce_nxt_s = bounce_sum_s[7:0];
            end
        end else begin
            bounce_nxt_s = bounce_r;
        end
    end

    // Render select: hit-test the pixel against the current (pre-update) box.
    always_comb begin
        px_s     = {1'b0, pix_x};
        py_s     = {1'b0, pix_y};
        bx_s     = {1'b0, box_x_r};
        by_s     = {1'b0, box_y_r};
        inside_s = (px_s >= bx_s) && (px_s <= bx_s + BOX_W_M1) &&
                   (py_s >= by_s) && (py_s <= by_s + BOX_H_M1);
        edge_s   = inside_s && ((px_s == bx_s) || (px_s == bx_s + BOX_W_M1) ||
                                (py_s == by_s) || (py_s == by_s + BOX_H_M1));
        if (!pix_active) begin
            colour_nxt_s = 16'h0000;
        end else if (edge_s) begin
            colour_nxt_s = BORDER_COLOR;
        end else if (inside_s) begin
            colour_nxt_s = BOX_COLOR;
        end else begin
            colour_nxt_s = BG_COLOR;
        end
    end

    // State register: motion state, divider, hit count and the colour pipeline.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            box_x_r        <= X_HOME;
            box_y_r        <= Y_HOME;
            dir_x_r        <= DIR_POS;
            dir_y_r        <= DIR_POS;
            div_cnt_r      <= '0;
            bounce_r       <= 8'd0;
            colour_r       <= 16'h0000;
            pix_active_q_r <= 1'b0;
        end else begin
            box_x_r        <= box_x_nxt_s;
            box_y_r        <= box_y_nxt_s;
            dir_x_r        <= dir_x_nxt_s;
            dir_y_r        <= dir_y_nxt_s;
            div_cnt_r      <= div_cnt_nxt_s;
            bounce_r       <= bounce_nxt_s;
            colour_r       <= colour_nxt_s;
            pix_active_q_r <= pix_active;
        end
    end

    assign vga_r        = colour_r[15:11];
    assign vga_g        = colour_r[10:5];
    assign vga_b        = colour_r[4:0];
    assign pix_active_q = pix_active_q_r;
    assign box_x        = box_x_r;
    assign box_y        = box_y_r;
    assign bounce_count = bounce_r;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer: a table of render vectors, random
// render/motion checks against a behavioural model, and hand-written
// sequences for walls, corners, saturation, enable and the frame divider.
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pix_x, pix_y;
    logic       pix_active;
    logic       tick_a, tick_c, tick_d;
    logic       enable;

    logic [4:0] r_a, b_a, r_c, b_c, r_d, b_d;
    logic [5:0] g_a, g_c, g_d;
    logic       pq_a, pq_c, pq_d;
    logic [9:0] bx_a, by_a, bx_c, by_c, bx_d, by_d;
    logic [7:0] bc_a, bc_c, bc_d;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = default, 1 = corner/saturation, 2 = divider
    int m_x[3], m_y[3], m_dx[3], m_dy[3], m_b[3], m_div[3];
    int lim_x[3], lim_y[3], stp[3], fd[3];

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [15:0] rgb;
    } vec_t;
    vec_t vecs[10];

    always #20 clk = ~clk;

    vga_box_renderer u_a (
        .clk25(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .pix_active(pix_active), .frame_tick(tick_a), .enable(enable),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .pix_active_q(pq_a),
        .box_x(bx_a), .box_y(by_a), .bounce_count(bc_a));

    vga_box_renderer #(.H_ACTIVE(96), .V_ACTIVE(96), .STEP(32)) u_c (
        .clk25(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .pix_active(pix_active), .frame_tick(tick_c), .enable(enable),
        .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .pix_active_q(pq_c),
        .box_x(bx_c), .box_y(by_c), .bounce_count(bc_c));

    vga_box_renderer #(.FRAME_DIV(3)) u_d (
        .clk25(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .pix_active(pix_active), .frame_tick(tick_d), .enable(enable),
        .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .pix_active_q(pq_d),
        .box_x(bx_d), .box_y(by_d), .bounce_count(bc_d));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected colour for a 32x32 box at (bx,by) with default colours
    function automatic logic [15:0] ref_colour(input int x, input int y, input logic act,
                                               input int bx, input int by, input int w);
        if (!act) return 16'h0000;
        if (x >= bx && x < bx + w && y >= by && y < by + w) begin
            if (x == bx || x == bx + w - 1 || y == by || y == by + w - 1) return 16'hFFFF;
            return 16'hF800;
        end
        return 16'h001F;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = lim_x[k] / 2;  m_y[k] = lim_y[k] / 2;
            m_dx[k] = 1;            m_dy[k] = 1;
            m_b[k] = 0;             m_div[k] = 0;
        end
    endtask

    // Move one coordinate by s toward dir, reflecting at 0 and lim
    task automatic axis(input int pos, input int dir, input int lim, input int s,
                        output int npos, output int ndir, output int hit);
        npos = pos; ndir = dir; hit = 0;
        if (dir > 0) begin
            if (pos + s >= lim) begin npos = lim; ndir = -1; hit = 1; end
            else npos = pos + s;
        end else begin
            if (pos <= s) begin npos = 0; ndir = 1; hit = 1; end
            else npos = pos - s;
        end
    endtask

    task automatic model_tick(input int k);
        int nx, ny, ndx, ndy, hx, hy;
        if (!enable) return;
        m_div[k]++;
        if (m_div[k] < fd[k]) return;
        m_div[k] = 0;
        axis(m_x[k], m_dx[k], lim_x[k], stp[k], nx, ndx, hx);
        axis(m_y[k], m_dy[k], lim_y[k], stp[k], ny, ndy, hy);
        m_x[k] = nx; m_dx[k] = ndx; m_y[k] = ny; m_dy[k] = ndy;
        m_b[k] = (m_b[k] + hx + hy > 255) ? 255 : m_b[k] + hx + hy;
    endtask

    task automatic do_tick(input int k);
        case (k)
            0:       tick_a = 1'b1;
            1:       tick_c = 1'b1;
            default: tick_d = 1'b1;
        endcase
        @(posedge clk); #1;
        tick_a = 1'b0; tick_c = 1'b0; tick_d = 1'b0;
        model_tick(k);
    endtask

    task automatic check_state(input int k, input string tag);
        case (k)
            0: begin
                check({tag, " box_x"}, 32'(bx_a), 32'(m_x[0]));
                check({tag, " box_y"}, 32'(by_a), 32'(m_y[0]));
                check({tag, " bounce"}, 32'(bc_a), 32'(m_b[0]));
            end
            1: begin
                check({tag, " box_x"}, 32'(bx_c), 32'(m_x[1]));
                check({tag, " box_y"}, 32'(by_c), 32'(m_y[1]));
                check({tag, " bounce"}, 32'(bc_c), 32'(m_b[1]));
            end
            default: begin
                check({tag, " box_x"}, 32'(bx_d), 32'(m_x[2]));
                check({tag, " box_y"}, 32'(by_d), 32'(m_y[2]));
                check({tag, " bounce"}, 32'(bc_d), 32'(m_b[2]));
            end
        endcase
    endtask

    task automatic render(input int x, input int y, input logic act);
        pix_x = 10'(x); pix_y = 10'(y); pix_active = act;
        @(posedge clk); #1;
    endtask

    task automatic random_render(input int n, input string tag);
        logic [15:0] exp;
        for (int i = 0; i < n; i++) begin
            int x, y;
            logic a;
            if ($urandom_range(0, 1) == 0) begin
                x = m_x[0] - 2 + int'($urandom_range(0, 35));
                y = m_y[0] - 2 + int'($urandom_range(0, 35));
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            a = ($urandom_range(0, 7) != 0);
            exp = ref_colour(x, y, a, m_x[0], m_y[0], 32);
            render(x, y, a);
            check({tag, " rgb"}, {16'd0, r_a, g_a, b_a}, {16'd0, exp});
            check({tag, " pq"}, 32'(pq_a), 32'(a));
        end
    endtask

    initial begin
        int guard;
        lim_x = '{608, 64, 608};
        lim_y = '{448, 64, 448};
        stp   = '{2, 32, 2};
        fd    = '{1, 1, 3};
        reset = 1'b1; pix_x = 10'd0; pix_y = 10'd0; pix_active = 1'b0;
        tick_a = 1'b0; tick_c = 1'b0; tick_d = 1'b0; enable = 1'b1;
        model_reset();

        vecs[0] = '{10'd304, 10'd224, 1'b1, 16'hFFFF};
        vecs[1] = '{10'd305, 10'd225, 1'b1, 16'hF800};
        vecs[2] = '{10'd336, 10'd224, 1'b1, 16'h001F};
        vecs[3] = '{10'd320, 10'd240, 1'b0, 16'h0000};
        vecs[4] = '{10'd335, 10'd240, 1'b1, 16'hFFFF};
        vecs[5] = '{10'd320, 10'd255, 1'b1, 16'hFFFF};
        vecs[6] = '{10'd320, 10'd256, 1'b1, 16'h001F};
        vecs[7] = '{10'd303, 10'd230, 1'b1, 16'h001F};
        vecs[8] = '{10'd700, 10'd230, 1'b1, 16'h001F};
        vecs[9] = '{10'd334, 10'd254, 1'b1, 16'hF800};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset rgb", {16'd0, r_a, g_a, b_a}, 32'd0);
        check("reset pq", 32'(pq_a), 32'd0);
        check("reset box_x", 32'(bx_a), 32'd304);
        check("reset box_y", 32'(by_a), 32'd224);
        check("reset bounce", 32'(bc_a), 32'd0);
        check("reset corner box_x", 32'(bx_c), 32'd32);

        // Render table at the home position
        for (int i = 0; i < 10; i++) begin
            render(int'(vecs[i].x), int'(vecs[i].y), vecs[i].act);
            check($sformatf("vec%0d rgb", i), {16'd0, r_a, g_a, b_a}, {16'd0, vecs[i].rgb});
            check($sformatf("vec%0d pq", i), 32'(pq_a), 32'(vecs[i].act));
        end
        random_render(100, "rand home");

        // Pixel on the tick cycle renders with the old position
        pix_x = 10'd304; pix_y = 10'd224; pix_active = 1'b1;
        do_tick(0);
        check("tick-cycle pixel", {16'd0, r_a, g_a, b_a}, 32'hFFFF);
        check("first update box_x", 32'(bx_a), 32'd306);
        check("first update box_y", 32'(by_a), 32'd226);
        render(305, 225, 1'b1);
        check("moved box bg", {16'd0, r_a, g_a, b_a}, 32'h001F);

        for (int i = 1; i < 112; i++) do_tick(0);
        check("y wall box_y", 32'(by_a), 32'd448);
        check("y wall bounce", 32'(bc_a), 32'd1);
        check_state(0, "y wall model");
        for (int i = 112; i < 152; i++) do_tick(0);
        check("x wall box_x", 32'(bx_a), 32'd608);
        check("x wall box_y", 32'(by_a), 32'd368);
        check("x wall bounce", 32'(bc_a), 32'd2);

        // Random enable walk to the X=0 wall, checked every tick
        guard = 0;
        while (!(m_x[0] == 0) && guard < 4000) begin
            enable = ($urandom_range(0, 3) != 0);
            do_tick(0);
            check_state(0, "walk");
            guard++;
        end
        check("walk reached x=0", 32'(guard < 4000), 32'd1);
        check("x clamp 0", 32'(bx_a), 32'd0);
        enable = 1'b1;
        random_render(60, "rand moved");

        // Enable low freezes position over 10 ticks
        begin
            int sx, sy, sb;
            sx = m_x[0]; sy = m_y[0]; sb = m_b[0];
            enable = 1'b0;
            for (int i = 0; i < 10; i++) do_tick(0);
            check("frozen box_x", 32'(bx_a), 32'(sx));
            check("frozen box_y", 32'(by_a), 32'(sy));
            check("frozen bounce", 32'(bc_a), 32'(sb));
            enable = 1'b1;
        end

        // Corner hit and saturation on the small screen
        do_tick(1);
        check("corner box_x", 32'(bx_c), 32'd64);
        check("corner box_y", 32'(by_c), 32'd64);
        check("corner bounce", 32'(bc_c), 32'd2);
        for (int i = 0; i < 260; i++) do_tick(1);
        check("saturate", 32'(bc_c), 32'd255);
        check_state(1, "sat model");
        for (int i = 0; i < 10; i++) do_tick(1);
        check("saturate hold", 32'(bc_c), 32'd255);

        // Frame divider of 3
        enable = 1'b0;
        for (int i = 0; i < 5; i++) do_tick(2);
        check("div disabled", 32'(bx_d), 32'd304);
        enable = 1'b1;
        do_tick(2); do_tick(2);
        check("div 2 ticks", 32'(bx_d), 32'd304);
        do_tick(2);
        check("div 3 ticks", 32'(bx_d), 32'd306);
        do_tick(2); do_tick(2); do_tick(2);
        check("div 6 ticks", 32'(bx_d), 32'd308);
        check_state(2, "div model");

        // Asynchronous reset mid-stream, checked with no clock edge
        render(m_x[0], m_y[0], 1'b1);
        check("pre-reset border", {16'd0, r_a, g_a, b_a}, 32'hFFFF);
        #4 reset = 1'b1;
        #1;
        check("async rgb", {16'd0, r_a, g_a, b_a}, 32'd0);
        check("async pq", 32'(pq_a), 32'd0);
        check("async box_x", 32'(bx_a), 32'd304);
        check("async box_y", 32'(by_a), 32'd224);
        check("async bounce", 32'(bc_a), 32'd0);
        check("async corner bounce", 32'(bc_c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
